// File: rtl/pipeline_hazard_controller_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller_pkg
// Description : Shared constants for the pipeline hazard controller.
//               This package holds the register address width, the default
//               MEM access length and the wait-state FSM encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_hazard_controller_pkg;

    // Register-file address width. It matches the regfile index width.
    localparam int DEF_REG_ADDR_W      = 4;

    // Default total cycles a MEM-stage SRAM access occupies. The legal range is 1..16.
    localparam int DEF_MEM_WAIT_CYCLES = 5;

    // Default width of the hazard-stall performance counter.
    localparam int DEF_STALL_CNT_W     = 16;

    // Wait-state FSM encoding.
    typedef logic [0:0] state_t;
    localparam state_t ST_IDLE = 1'b0;
    localparam state_t ST_WAIT = 1'b1;

endpackage : pipeline_hazard_controller_pkg
`default_nettype wire

// File: rtl/pipeline_hazard_controller_hazard_detect.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller_hazard_detect
// Description : Read-after-write hazard detector. It compares the ID-stage
//               source operands against the EXE and MEM destinations.
//               With forwarding active, only a load in EXE stalls the pipeline.
//               Purely combinational.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller_hazard_detect #(
    parameter int REG_ADDR_W = 4
) (
    input  logic [REG_ADDR_W-1:0] id_src1,
    input  logic [REG_ADDR_W-1:0] id_src2,
    input  logic                  id_src1_valid,
    input  logic                  id_two_src,
    input  logic [REG_ADDR_W-1:0] exe_dest,
    input  logic                  exe_wb_en,
    input  logic                  exe_mem_read,
    input  logic [REG_ADDR_W-1:0] mem_dest,
    input  logic                  mem_wb_en,
    input  logic                  forward_en,
    output logic                  haz
);

    logic w_exe_match;
    logic w_mem_match;

    // A destination matches when a source that is actually read names the same register.
    assign w_exe_match = (id_src1_valid && (id_src1 == exe_dest)) ||
                         (id_two_src    && (id_src2 == exe_dest));
    assign w_mem_match = (id_src1_valid && (id_src1 == mem_dest)) ||
                         (id_two_src    && (id_src2 == mem_dest));

    // The forwarding network covers every RAW case except load-use.
    // A loaded value only exists after MEM, so that case still stalls.
    assign haz = forward_en ? (exe_wb_en && exe_mem_read && w_exe_match)
                            : ((exe_wb_en && w_exe_match) || (mem_wb_en && w_mem_match));

endmodule : pipeline_hazard_controller_hazard_detect
`default_nettype wire

// File: rtl/pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_hazard_controller
// Description : Central stall/flush/freeze sequencing for the five-stage
//               pipeline. It combines RAW hazard stalls and taken-branch
//               flushes with the MEM-stage wait-state FSM. It also keeps a
//               saturating count of hazard-stall cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_controller
    import pipeline_hazard_controller_pkg::*;
#(
    parameter int REG_ADDR_W      = DEF_REG_ADDR_W,
    parameter int MEM_WAIT_CYCLES = DEF_MEM_WAIT_CYCLES,
    parameter int STALL_CNT_W     = DEF_STALL_CNT_W
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [REG_ADDR_W-1:0]  id_src1,
    input  logic [REG_ADDR_W-1:0]  id_src2,
    input  logic                   id_src1_valid,
    input  logic                   id_two_src,
    input  logic [REG_ADDR_W-1:0]  exe_dest,
    input  logic                   exe_wb_en,
    input  logic                   exe_mem_read,
    input  logic [REG_ADDR_W-1:0]  mem_dest,
    input  logic                   mem_wb_en,
    input  logic                   mem_req,
    input  logic                   forward_en,
    input  logic                   branch_taken,
    output logic                   pc_freeze,
    output logic                   id_exe_bubble,
    output logic                   if_id_flush,
    output logic                   freeze_all,
    output logic                   mem_last,
    output logic [STALL_CNT_W-1:0] stall_count
);

    // The counter is loaded with MEM_WAIT_CYCLES-2 on entry to WAIT.
    // The WAIT cycle at cnt==0 is the release cycle. Together with the IDLE
    // entry cycle, this gives MEM_WAIT_CYCLES-1 frozen cycles in total.
    localparam logic c_MULTI_CYCLE = (MEM_WAIT_CYCLES > 1);
    localparam int   c_CNT_LOAD    = (MEM_WAIT_CYCLES > 1) ? (MEM_WAIT_CYCLES - 2) : 0;
    localparam int   c_CNT_W       = (MEM_WAIT_CYCLES > 2) ? $clog2(MEM_WAIT_CYCLES - 1) : 1;

    state_t                 r_state;
    state_t                 w_state_next;
    logic [c_CNT_W-1:0]     r_cnt;
    logic [c_CNT_W-1:0]     w_cnt_next;
    logic [STALL_CNT_W-1:0] r_stall_count;

    logic                   w_haz;
    logic                   w_freeze_all;
    logic                   w_mem_last;
    logic                   w_pc_freeze;
    logic                   w_id_exe_bubble;
    logic                   w_if_id_flush;

    pipeline_hazard_controller_hazard_detect #(
        .REG_ADDR_W (REG_ADDR_W)
    ) u_hazard_detect (
        .id_src1       (id_src1),
        .id_src2       (id_src2),
        .id_src1_valid (id_src1_valid),
        .id_two_src    (id_two_src),
        .exe_dest      (exe_dest),
        .exe_wb_en     (exe_wb_en),
        .exe_mem_read  (exe_mem_read),
        .mem_dest      (mem_dest),
        .mem_wb_en     (mem_wb_en),
        .forward_en    (forward_en),
        .haz           (w_haz)
    );

    // Wait-state FSM register and its cycle counter. Reset abandons any access in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Next-state logic. mem_req is only looked at in IDLE, never while WAIT is running.
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (mem_req && c_MULTI_CYCLE) begin
                    w_state_next = ST_WAIT;
                    w_cnt_next   = c_CNT_W'(c_CNT_LOAD);
                end
            end
            ST_WAIT: begin
                if (r_cnt != '0) begin
                    w_cnt_next = r_cnt - 1'b1;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
                w_cnt_next   = '0;
            end
        endcase
    end

    // FSM outputs (Mealy in IDLE) and the stage-control priority: freeze > branch > hazard.
    always_comb begin
        w_freeze_all    = 1'b0;
        w_mem_last      = 1'b0;
        w_pc_freeze     = 1'b0;
        w_id_exe_bubble = 1'b0;
        w_if_id_flush   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (mem_req) begin
                    w_freeze_all = c_MULTI_CYCLE;
                    w_mem_last   = !c_MULTI_CYCLE;
                end
            end
            ST_WAIT: begin
                w_freeze_all = (r_cnt != '0);
                w_mem_last   = (r_cnt == '0);
            end
            default: begin
                w_freeze_all = 1'b0;
                w_mem_last   = 1'b0;
            end
        endcase

        // While frozen, nothing moves. The branch or hazard is still present after release and is acted on then.
        if (!w_freeze_all) begin
            if (branch_taken) begin
                w_if_id_flush   = 1'b1;
                w_id_exe_bubble = 1'b1;
            end else if (w_haz) begin
                w_pc_freeze     = 1'b1;
                w_id_exe_bubble = 1'b1;
            end
        end

        // Reset holds every control output low, whatever the inputs are doing.
        if (rst) begin
            w_freeze_all    = 1'b0;
            w_mem_last      = 1'b0;
            w_pc_freeze     = 1'b0;
            w_id_exe_bubble = 1'b0;
            w_if_id_flush   = 1'b0;
        end
    end

    // Saturating count of hazard-stall cycles. It does not wrap, so it stays meaningful on long runs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_stall_count <= '0;
        end else if (w_pc_freeze && (r_stall_count != '1)) begin
            r_stall_count <= r_stall_count + 1'b1;
        end
    end

    assign pc_freeze     = w_pc_freeze;
    assign id_exe_bubble = w_id_exe_bubble;
    assign if_id_flush   = w_if_id_flush;
    assign freeze_all    = w_freeze_all;
    assign mem_last      = w_mem_last;
    assign stall_count   = r_stall_count;

endmodule : pipeline_hazard_controller
`default_nettype wire

// File: tb/tb_pipeline_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipeline_hazard_controller
// Description : Directed self-checking bench for pipeline_hazard_controller.
//               It uses the default configuration: 4-bit regs, 5-cycle MEM
//               access and a 16-bit stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_controller;

    logic        clk;
    logic        rst;
    logic [3:0]  id_src1;
    logic [3:0]  id_src2;
    logic        id_src1_valid;
    logic        id_two_src;
    logic [3:0]  exe_dest;
    logic        exe_wb_en;
    logic        exe_mem_read;
    logic [3:0]  mem_dest;
    logic        mem_wb_en;
    logic        mem_req;
    logic        forward_en;
    logic        branch_taken;
    logic        pc_freeze;
    logic        id_exe_bubble;
    logic        if_id_flush;
    logic        freeze_all;
    logic        mem_last;
    logic [15:0] stall_count;

    int n_cmp;
    int n_err;

    pipeline_hazard_controller #(
        .REG_ADDR_W      (4),
        .MEM_WAIT_CYCLES (5),
        .STALL_CNT_W     (16)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .id_src1       (id_src1),
        .id_src2       (id_src2),
        .id_src1_valid (id_src1_valid),
        .id_two_src    (id_two_src),
        .exe_dest      (exe_dest),
        .exe_wb_en     (exe_wb_en),
        .exe_mem_read  (exe_mem_read),
        .mem_dest      (mem_dest),
        .mem_wb_en     (mem_wb_en),
        .mem_req       (mem_req),
        .forward_en    (forward_en),
        .branch_taken  (branch_taken),
        .pc_freeze     (pc_freeze),
        .id_exe_bubble (id_exe_bubble),
        .if_id_flush   (if_id_flush),
        .freeze_all    (freeze_all),
        .mem_last      (mem_last),
        .stall_count   (stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks all five control outputs at once, packed as {pc_freeze, bubble, flush, freeze_all, mem_last}.
    task automatic check_ctl(input string tag, input logic [4:0] exp);
        check(tag, {27'd0, pc_freeze, id_exe_bubble, if_id_flush, freeze_all, mem_last}, {27'd0, exp});
    endtask

    // Inputs change 1 time unit after the rising edge. Outputs are checked 1 time unit after that, still well before the next edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic clear_inputs();
        id_src1 = 4'd0; id_src2 = 4'd0; id_src1_valid = 1'b0; id_two_src = 1'b0;
        exe_dest = 4'd0; exe_wb_en = 1'b0; exe_mem_read = 1'b0;
        mem_dest = 4'd0; mem_wb_en = 1'b0; mem_req = 1'b0;
        forward_en = 1'b0; branch_taken = 1'b0;
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        clear_inputs();

        // Reset: outputs are held low even with a branch and a MEM request present.
        rst = 1'b1;
        branch_taken = 1'b1;
        mem_req = 1'b1;
        settle();
        check_ctl("reset_ctl", 5'b00000);
        check("reset_stall_count", {16'd0, stall_count}, 32'd0);
        tick();
        tick();
        rst = 1'b0;
        clear_inputs();
        settle();
        check_ctl("idle_ctl", 5'b00000);

        // 1. No forwarding: src1 against the EXE destination.
        id_src1 = 4'd3; id_src1_valid = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
        settle();
        check_ctl("nofwd_exe_haz", 5'b11000);
        tick();
        clear_inputs();
        settle();
        check("stall_count_1", {16'd0, stall_count}, 32'd1);
        check_ctl("nofwd_cleared", 5'b00000);

        // No forwarding: src2 against the MEM destination.
        id_two_src = 1'b1; id_src2 = 4'd7; mem_dest = 4'd7; mem_wb_en = 1'b1;
        settle();
        check_ctl("nofwd_mem_src2_haz", 5'b11000);
        tick();
        // The same registers without id_two_src must not stall.
        id_two_src = 1'b0;
        settle();
        check("stall_count_2", {16'd0, stall_count}, 32'd2);
        check_ctl("src2_unused_no_haz", 5'b00000);
        // A match is ignored when wb_en is low.
        clear_inputs();
        id_src1 = 4'd9; id_src1_valid = 1'b1; exe_dest = 4'd9; mem_dest = 4'd9;
        settle();
        check_ctl("no_wb_en_no_haz", 5'b00000);

        // 2. Forwarding: an ALU result in EXE does not stall, but a load in EXE does.
        clear_inputs();
        forward_en = 1'b1;
        id_src1 = 4'd5; id_src1_valid = 1'b1; exe_dest = 4'd5; exe_wb_en = 1'b1;
        mem_dest = 4'd5; mem_wb_en = 1'b1;
        settle();
        check_ctl("fwd_alu_no_stall", 5'b00000);
        exe_mem_read = 1'b1;
        settle();
        check_ctl("fwd_load_use_stall", 5'b11000);
        tick();
        clear_inputs();
        settle();
        check("stall_count_3", {16'd0, stall_count}, 32'd3);

        // 4. A branch has priority over a hazard.
        id_src1 = 4'd3; id_src1_valid = 1'b1; exe_dest = 4'd3; exe_wb_en = 1'b1;
        branch_taken = 1'b1;
        settle();
        check_ctl("branch_over_haz", 5'b01100);
        tick();
        clear_inputs();
        settle();
        check("stall_count_branch", {16'd0, stall_count}, 32'd3);

        // 3 and 5: a MEM access with a branch held taken throughout.
        // The 4 frozen cycles suppress the flush, then the release cycle flushes.
        mem_req = 1'b1;
        branch_taken = 1'b1;
        id_src1 = 4'd2; id_src1_valid = 1'b1; exe_dest = 4'd2; exe_wb_en = 1'b1;
        settle();
        check_ctl("mem_frz_1", 5'b00010);
        tick();
        mem_req = 1'b0;
        for (int i = 2; i <= 4; i++) begin
            settle();
            check_ctl($sformatf("mem_frz_%0d", i), 5'b00010);
            tick();
        end
        settle();
        check_ctl("mem_release", 5'b01101);
        tick();
        settle();
        check_ctl("mem_after_idle", 5'b01100);
        check("stall_count_mem", {16'd0, stall_count}, 32'd3);

        // 6. Reset during WAIT when cnt=2, i.e. in the 3rd frozen cycle.
        clear_inputs();
        mem_req = 1'b1;
        settle();
        check_ctl("rst_pre_frz_1", 5'b00010);
        tick();
        mem_req = 1'b0;
        settle();
        check_ctl("rst_pre_frz_2", 5'b00010);
        tick();
        rst = 1'b1;
        settle();
        check_ctl("rst_mid_wait_ctl", 5'b00000);
        check("rst_mid_wait_stall_count", {16'd0, stall_count}, 32'd0);
        tick();
        rst = 1'b0;
        settle();
        check_ctl("rst_after_idle", 5'b00000);

        // A new access after reset gets the full 4 frozen cycles.
        // mem_req stays high, so the next access starts right after the release cycle.
        mem_req = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            settle();
            check_ctl($sformatf("post_rst_frz_%0d", i), 5'b00010);
            tick();
        end
        settle();
        check_ctl("post_rst_release", 5'b00001);
        tick();
        settle();
        check_ctl("back_to_back_start", 5'b00010);
        check("final_stall_count", {16'd0, stall_count}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    // Overall time limit so the bench cannot hang.
    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, observed running required finished");
        $fatal(1, "timeout");
    end

endmodule : tb_pipeline_hazard_controller
`default_nettype wire
